// File: rtl/mips_regfile_mp.sv
// Multi-read-port register file with optional hardwired-zero entry and a clear sequencer.
// Define MIPS_REGFILE_BYPASS_EN to forward same-cycle write data to colliding reads.
module mips_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0]           r_en,
    input  logic [NRD*ADDR_W-1:0]    r_addr,
    output logic [NRD*DATA_W-1:0]    r_data,
    input  logic                     w_en,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       clr_ptr_q, clr_ptr_d;
    logic                    busy_q, busy_d;
    logic [NRD*DATA_W-1:0]   r_data_q, r_data_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    mem_we_s;
    logic [ADDR_W-1:0]       mem_waddr_s;
    logic [DATA_W-1:0]       mem_wdata_s;
    logic                    write_ok_s;
    logic [ADDR_W-1:0]       rd_addr_s [NRD];
    logic [DATA_W-1:0]       rd_val_s  [NRD];

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Per-port read value: array contents, optional forwarding, then the zero-register override.
    always_comb begin
        write_ok_s = w_en && !clr_req && !is_zero_addr(w_addr);
        for (int i = 0; i < NRD; i++) begin
            rd_addr_s[i] = r_addr[i*ADDR_W +: ADDR_W];
            rd_val_s[i]  = mem_q[rd_addr_s[i]];
`ifdef MIPS_REGFILE_BYPASS_EN
            if (write_ok_s && (rd_addr_s[i] == w_addr)) begin
                rd_val_s[i] = w_data;
            end else begin
                rd_val_s[i] = mem_q[rd_addr_s[i]];
            end
`endif
            if (is_zero_addr(rd_addr_s[i])) begin
                rd_val_s[i] = '0;
            end else begin
                rd_val_s[i] = rd_val_s[i];
            end
        end
    end

    // Next-state logic for the clear sequencer, array write port and read registers.
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        busy_d      = busy_q;
        r_data_d    = r_data_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = w_addr;
        mem_wdata_s = w_data;
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = '0;
                clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
                r_data_d    = '0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end else begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                end
            end
            READY: begin
                mem_we_s = write_ok_s;
                for (int i = 0; i < NRD; i++) begin
                    if (r_en[i]) begin
                        r_data_d[i*DATA_W +: DATA_W] = rd_val_s[i];
                    end else begin
                        r_data_d[i*DATA_W +: DATA_W] = r_data_q[i*DATA_W +: DATA_W];
                    end
                end
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
                busy_d    = 1'b1;
                r_data_d  = '0;
            end
        endcase
    end

    // Sequencer state and registered outputs; the array itself is zeroed by the sweep, not by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            r_data_q  <= r_data_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign r_data = r_data_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Directed bench for mips_regfile_mp: a default instance (ZERO_REG=1, NRD=2) plus a ZERO_REG=0 single-port instance.
module tb_mips_regfile_mp;

    logic        clk;
    logic        rst;
    logic [1:0]  r_en;
    logic [9:0]  r_addr;
    logic [63:0] r_data;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        clr_req;
    logic        busy;

    logic        nz_r_en;
    logic [4:0]  nz_r_addr;
    logic [31:0] nz_r_data;
    logic        nz_w_en;
    logic [4:0]  nz_w_addr;
    logic [31:0] nz_w_data;
    logic        nz_busy;

    int checks;
    int failures;
    int cnt;

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst(rst), .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .clr_req(clr_req), .busy(busy)
    );

    mips_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(1), .ZERO_REG(1'b0)) u_dut_nz (
        .clk(clk), .rst(rst), .r_en(nz_r_en), .r_addr(nz_r_addr), .r_data(nz_r_data),
        .w_en(nz_w_en), .w_addr(nz_w_addr), .w_data(nz_w_data), .clr_req(1'b0), .busy(nz_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        w_en = 1'b1; w_addr = a; w_data = d;
        tick();
        w_en = 1'b0;
    endtask

    task automatic read_regs(input logic [4:0] a1, input logic [4:0] a0, input logic [1:0] en);
        r_en = en; r_addr = {a1, a0};
        tick();
        r_en = 2'b00;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; r_en = 2'b00; r_addr = 10'd0; w_en = 1'b0; w_addr = 5'd0; w_data = 32'd0; clr_req = 1'b0;
        nz_r_en = 1'b0; nz_r_addr = 5'd0; nz_w_en = 1'b0; nz_w_addr = 5'd0; nz_w_data = 32'd0;
        #2;
        check_val("rst_busy", {63'd0, busy}, 64'd1);
        check_val("rst_rdata", r_data, 64'd0);
        tick(); tick();
        rst = 1'b0;
        wait_idle(cnt);
        check_val("init_busy_len", 64'(cnt), 64'd32);
        check_val("nz_busy_done", {63'd0, nz_busy}, 64'd0);

        for (int a = 0; a < 32; a++) begin
            read_regs(5'(31 - a), 5'(a), 2'b11);
            check_val("init_zero", r_data, 64'd0);
        end

        write_reg(5'd5, 32'hDEADBEEF);
        read_regs(5'd5, 5'd5, 2'b11);
        check_val("rd_both_ports", r_data, {32'hDEADBEEF, 32'hDEADBEEF});
        r_addr = 10'd0;
        tick(); tick();
        check_val("rd_hold", r_data, {32'hDEADBEEF, 32'hDEADBEEF});

        write_reg(5'd9, 32'hCAFEF00D);
        read_regs(5'd5, 5'd9, 2'b11);
        check_val("rd_distinct", r_data, {32'hDEADBEEF, 32'hCAFEF00D});
        read_regs(5'd0, 5'd5, 2'b01);
        check_val("rd_port1_hold", r_data, {32'hDEADBEEF, 32'hDEADBEEF});

        write_reg(5'd0, 32'h12345678);
        read_regs(5'd0, 5'd0, 2'b11);
        check_val("zero_reg", r_data, 64'd0);

        nz_w_en = 1'b1; nz_w_addr = 5'd0; nz_w_data = 32'h12345678;
        tick();
        nz_w_en = 1'b0; nz_r_en = 1'b1; nz_r_addr = 5'd0;
        tick();
        nz_r_en = 1'b0;
        check_val("nz_reg0", {32'd0, nz_r_data}, {32'd0, 32'h12345678});

        write_reg(5'd7, 32'h1);
        w_en = 1'b1; w_addr = 5'd7; w_data = 32'h2;
        r_en = 2'b01; r_addr = {5'd0, 5'd7};
        tick();
        w_en = 1'b0; r_en = 2'b00;
`ifdef MIPS_REGFILE_BYPASS_EN
        check_val("collide", {32'd0, r_data[31:0]}, 64'h2);
`else
        check_val("collide", {32'd0, r_data[31:0]}, 64'h1);
`endif
        read_regs(5'd0, 5'd7, 2'b01);
        check_val("collide_after", {32'd0, r_data[31:0]}, 64'h2);

        read_regs(5'd0, 5'd5, 2'b01);
        w_en = 1'b1; w_addr = 5'd0; w_data = 32'hFFFF;
        r_en = 2'b01; r_addr = {5'd0, 5'd0};
        tick();
        w_en = 1'b0; r_en = 2'b00;
        check_val("collide_zero", {32'd0, r_data[31:0]}, 64'd0);

        write_reg(5'd3, 32'hAAAA);
        clr_req = 1'b1; w_en = 1'b1; w_addr = 5'd4; w_data = 32'h5555;
        r_en = 2'b01; r_addr = {5'd0, 5'd3};
        tick();
        clr_req = 1'b0; r_en = 2'b00;
        check_val("clr_busy_rise", {63'd0, busy}, 64'd1);
        check_val("clr_read_done", {32'd0, r_data[31:0]}, 64'hAAAA);
        // Keep writing entry 1 throughout the sweep; every one must be ignored.
        w_addr = 5'd1; w_data = 32'h1111;
        cnt = 0;
        while (busy && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 1) check_val("clr_rdata_zero", r_data, 64'd0);
        end
        w_en = 1'b0;
        check_val("clr_busy_len", 64'(cnt), 64'd32);
        read_regs(5'd4, 5'd3, 2'b11);
        check_val("clr_entries", r_data, 64'd0);
        read_regs(5'd1, 5'd1, 2'b11);
        check_val("clr_wr_ignored", r_data, 64'd0);

        write_reg(5'd20, 32'h77);
        read_regs(5'd20, 5'd20, 2'b11);
        check_val("pre_rst_read", r_data, {32'h77, 32'h77});
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_rdata", r_data, 64'd0);
        check_val("async_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        wait_idle(cnt);
        check_val("rst_ready_len", 64'(cnt), 64'd32);
        read_regs(5'd20, 5'd20, 2'b11);
        check_val("rst_ready_clear", r_data, 64'd0);

        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check_val("midclr_busy", {63'd0, busy}, 64'd1);
        check_val("midclr_rdata", r_data, 64'd0);
        rst = 1'b0;
        wait_idle(cnt);
        check_val("midclr_len", 64'(cnt), 64'd32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
